alu_writeback: RTL and testbench
================================

# alu_writeback

Writeback stage directly downstream of the `alu` block. Accepts one ALU result per handshake, holds it for one cycle in a commit register, and then writes it into an 8-entry × 32-bit register file and the 4-bit APSR (N Z C V). It also provides the combinational read port that supplies the ALU's `rn` operand. That port has optional same-cycle bypass of the pending commit, and a retired-instruction counter.

## Interface
Parameters:
- `REGS`, default 8: register-file depth. Address width is `$clog2(REGS)`, 3 at the default.
- `CNT_W`, default 16: retired-counter width.

Ports:
- `i_clk`, input, 1: single clock for the block; rising edge.
- `i_rst_n`, input, 1: reset. Asynchronous and active-low.
- `i_valid`, input, 1: ALU result presented.
- `o_ready`, output, 1: stage can accept a result this cycle.
- `i_result`, input, 32: ALU result.
- `i_apsr`, input, 4: ALU flags `{N,Z,C,V}`.
- `i_rd`, input, 3: destination register.
- `i_we`, input, 1: write `i_rd`. Low for compare-type ops.
- `i_setflags`, input, 1: update APSR from `i_apsr`.
- `i_hold`, input, 1: freeze commit (debug/halt).
- `i_rn_addr`, input, 3: operand read address.
- `o_rn_data`, output, 32: operand read data; drives ALU `i_rn`.
- `i_flags_rd`, input, 1: consumer reads APSR this cycle.
- `o_apsr`, output, 4: architectural (or bypassed) APSR.
- `o_hazard`, output, 1: read data stale. Upstream must not issue.
- `o_retired`, output, `CNT_W`: count of committed results.

## Operation
- **Commit register S1** holds `s1_valid`, `s1_result`, `s1_apsr`, `s1_rd`, `s1_we`, `s1_setflags`.
- **Handshake.** `o_ready = !s1_valid || !i_hold`. A transfer occurs on a clock edge where `i_valid && o_ready`. `i_valid` is not required to stay high without a transfer.
- **Commit.** On an edge with `s1_valid && !i_hold`:
  - if `s1_we`, write `regs[s1_rd] <= s1_result`;
  - if `s1_setflags`, write `apsr_r <= s1_apsr`;
  - increment `o_retired`, wrapping modulo 2^`CNT_W`.
- **S1 update on each edge:**
  - a transfer loads S1 with the inputs and sets `s1_valid = 1`;
  - otherwise, a commit clears `s1_valid`;
  - otherwise, S1 holds.
- **Back-to-back.** Commit and transfer on the same edge is legal: the old S1 content commits and the new content loads. This sustains one result per cycle.
- **`i_hold` with `s1_valid = 0`** has no effect: `o_ready = 1`, and the first result loads but does not commit until `i_hold` falls.
- **Read port.** `o_rn_data = regs[i_rn_addr]`, subject to the bypass rules under Configuration.
- **`o_apsr`** is `apsr_r`, subject to the bypass rules under Configuration.
- **Hazard.** `o_hazard` is combinational and depends on Configuration. It does not gate `o_ready`; the issuing stage must hold `i_valid` low while it is high.
- **Reset (asynchronous, `i_rst_n = 0`):** all `regs` = 0, `apsr_r` = 0, `s1_valid` = 0, S1 fields = 0, `o_retired` = 0.
- **Reset mid-operation:** a pending S1 result is discarded and is not committed.

## Timing
- **Latency.** A result transferred on edge N is architecturally visible (regfile or APSR) after edge N+1, provided `i_hold` is low at N+1.
- **Hold.** Each cycle `i_hold` is high with `s1_valid = 1` delays the commit by one cycle. During that time `o_ready` = 0.
- `o_rn_data`, `o_apsr` and `o_hazard` are combinational from the address/flag inputs and state; there are no output registers.
- **Reset output values** (read with `i_rn_addr` = any): `o_ready` = 1, `o_rn_data` = 0, `o_apsr` = 0, `o_hazard` = 0, `o_retired` = 0.

## Configuration
Macro `ALU_WB_BYPASS_EN`.
- **Defined:**
  - `o_rn_data = s1_result` when `s1_valid && s1_we && s1_rd == i_rn_addr`;
  - `o_apsr = s1_apsr` when `s1_valid && s1_setflags`;
  - otherwise both come from architectural state;
  - `o_hazard` is tied to 0.
- **Not defined:**
  - no bypass; the outputs always show architectural state;
  - `o_hazard = s1_valid && ((s1_we && s1_rd == i_rn_addr) || (s1_setflags && i_flags_rd))`.

## Test plan
- **Reset:** assert `i_rst_n = 0` mid-transfer with `s1_valid = 1` -> `regs[rd]` stays 0, `o_retired` = 0, `o_ready` = 1.
- **Single write:** transfer `rd = 3`, `result = 0x0000_00A5`, `we = 1`, `setflags = 1`, `apsr = 4'b0100`; then read `rn_addr = 3` two cycles later -> `o_rn_data = 0xA5`, `o_apsr = 4'b0100`, `o_retired = 1`.
- **Back-to-back:** results to r1 = 0x10, r2 = 0x20, r1 = 0x30 on three consecutive edges, with `o_ready` high throughout -> final r1 = 0x30, r2 = 0x20, `o_retired = 3`.
- **Hold:** `i_hold = 1` for 3 cycles with S1 full -> `o_ready = 0` for 3 cycles and the regfile is unchanged; commit occurs on the first edge after `i_hold` falls.
- **Compare:** `we = 0`, `setflags = 1`, `rd = 5` (r5 = 0x7) -> r5 stays 0x7 and APSR updates.
- **Pending-read check (both builds):** S1 holds r4 = 0xDEAD_BEEF with `rn_addr = 4`.
  - With `ALU_WB_BYPASS_EN`: `o_rn_data = 0xDEADBEEF`, `o_hazard = 0`.
  - Without it: `o_rn_data` = old r4, `o_hazard = 1` until the commit.
- **Counter wrap:** with `CNT_W = 4`, 17 commits -> `o_retired = 1`.

Source files
------------

// File: rtl/alu_writeback_if.sv
// alu_writeback_if: result bus from the ALU into the writeback stage.
// Carries one ALU result plus destination/flag controls under a valid/ready handshake.
// The ALU side is the master; the writeback stage is the slave and owns o_ready.
interface alu_writeback_if #(
  parameter int AW = 3
);
  logic          i_valid;
  logic          o_ready;
  logic [31:0]   i_result;
  logic [3:0]    i_apsr;
  logic [AW-1:0] i_rd;
  logic          i_we;
  logic          i_setflags;

  modport master (
    output i_valid, i_result, i_apsr, i_rd, i_we, i_setflags,
    input  o_ready
  );

  modport slave (
    input  i_valid, i_result, i_apsr, i_rd, i_we, i_setflags,
    output o_ready
  );
endinterface

// File: rtl/alu_writeback.sv
// alu_writeback: one-entry commit register feeding an REGS x 32 regfile and the NZCV APSR.
// Latency: a result transferred on edge N becomes architectural on edge N+1 (later if i_hold).
// Backpressure: o_ready is low only while S1 is occupied and i_hold freezes the commit.
// Optional build macro ALU_WB_BYPASS_EN: forward the pending S1 result/flags to the read
// ports and tie o_hazard low; without it the read ports show architectural state only and
// o_hazard flags a read that the pending commit would change.
module alu_writeback #(
  parameter  int REGS  = 8,
  parameter  int CNT_W = 16,
  localparam int AW    = (REGS > 1) ? $clog2(REGS) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  alu_writeback_if.slave   wb,
  input  logic             i_hold,
  input  logic [AW-1:0]    i_rn_addr,
  output logic [31:0]      o_rn_data,
  input  logic             i_flags_rd,
  output logic [3:0]       o_apsr,
  output logic             o_hazard,
  output logic [CNT_W-1:0] o_retired
);

  // Commit register S1
  logic          r_s1_valid;
  logic [31:0]   r_s1_result;
  logic [3:0]    r_s1_apsr;
  logic [AW-1:0] r_s1_rd;
  logic          r_s1_we;
  logic          r_s1_setflags;

  // Architectural state
  logic [31:0]      r_regs [REGS];
  logic [3:0]       r_apsr;
  logic [CNT_W-1:0] r_retired;

  logic w_xfer;
  logic w_commit;
  logic w_rn_hit;
  logic w_flags_pending;

  // A full S1 frozen by i_hold is the only thing that blocks a new result;
  // an empty S1 always accepts, even under hold.
  assign wb.o_ready = !r_s1_valid || !i_hold;
  assign w_xfer     = wb.i_valid && wb.o_ready;
  assign w_commit   = r_s1_valid && !i_hold;

  // Pending S1 content that a read this cycle would observe once committed
  assign w_rn_hit        = r_s1_valid && r_s1_we && (r_s1_rd == i_rn_addr);
  assign w_flags_pending = r_s1_valid && r_s1_setflags;

  // S1 load on transfer, drain on commit-without-transfer, otherwise hold
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid    <= 1'b0;
      r_s1_result   <= '0;
      r_s1_apsr     <= '0;
      r_s1_rd       <= '0;
      r_s1_we       <= 1'b0;
      r_s1_setflags <= 1'b0;
    end else if (w_xfer) begin
      r_s1_valid    <= 1'b1;
      r_s1_result   <= wb.i_result;
      r_s1_apsr     <= wb.i_apsr;
      r_s1_rd       <= wb.i_rd;
      r_s1_we       <= wb.i_we;
      r_s1_setflags <= wb.i_setflags;
    end else if (w_commit) begin
      r_s1_valid    <= 1'b0;
    end
  end

  // Register-file write of the committing S1 result
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_commit && r_s1_we) begin
      r_regs[r_s1_rd] <= r_s1_result;
    end
  end

  // APSR update from the committing S1 flags
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_apsr <= '0;
    end else if (w_commit && r_s1_setflags) begin
      r_apsr <= r_s1_apsr;
    end
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_retired <= '0;
    end else if (w_commit) begin
      r_retired <= r_retired + 1'b1;
    end
  end

  assign o_retired = r_retired;

`ifdef ALU_WB_BYPASS_EN
  // Read ports forward the pending commit, so a consumer never sees stale data
  always_comb begin
    o_rn_data = r_regs[i_rn_addr];
    o_apsr    = r_apsr;
    o_hazard  = 1'b0;
    if (w_rn_hit) begin
      o_rn_data = r_s1_result;
    end
    if (w_flags_pending) begin
      o_apsr = r_s1_apsr;
    end
  end
`else
  // Read ports show architectural state; flag reads the pending commit would change
  always_comb begin
    o_rn_data = r_regs[i_rn_addr];
    o_apsr    = r_apsr;
    o_hazard  = w_rn_hit || (w_flags_pending && i_flags_rd);
  end
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback: directed tests of the writeback stage in either bypass build.
// A second instance with a 4-bit retired counter shares the stimulus to check wrap.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_alu_writeback;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_hold;
  logic [2:0]  i_rn_addr;
  logic        i_flags_rd;

  logic [31:0] o_rn_data;
  logic [3:0]  o_apsr;
  logic        o_hazard;
  logic [15:0] o_retired;

  logic [31:0] o_rn_data4;
  logic [3:0]  o_apsr4;
  logic        o_hazard4;
  logic [3:0]  o_retired4;

  int checks;
  int failures;

  alu_writeback_if #(.AW(3)) wb  ();
  alu_writeback_if #(.AW(3)) wb4 ();

  assign wb4.i_valid    = wb.i_valid;
  assign wb4.i_result   = wb.i_result;
  assign wb4.i_apsr     = wb.i_apsr;
  assign wb4.i_rd       = wb.i_rd;
  assign wb4.i_we       = wb.i_we;
  assign wb4.i_setflags = wb.i_setflags;

  alu_writeback #(.REGS(8), .CNT_W(16)) u_dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .wb         (wb),
    .i_hold     (i_hold),
    .i_rn_addr  (i_rn_addr),
    .o_rn_data  (o_rn_data),
    .i_flags_rd (i_flags_rd),
    .o_apsr     (o_apsr),
    .o_hazard   (o_hazard),
    .o_retired  (o_retired)
  );

  alu_writeback #(.REGS(8), .CNT_W(4)) u_dut4 (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .wb         (wb4),
    .i_hold     (i_hold),
    .i_rn_addr  (i_rn_addr),
    .o_rn_data  (o_rn_data4),
    .i_flags_rd (i_flags_rd),
    .o_apsr     (o_apsr4),
    .o_hazard   (o_hazard4),
    .o_retired  (o_retired4)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] rd, input logic [31:0] res,
                       input logic we, input logic sf, input logic [3:0] apsr);
    wb.i_valid    = v;
    wb.i_rd       = rd;
    wb.i_result   = res;
    wb.i_we       = we;
    wb.i_setflags = sf;
    wb.i_apsr     = apsr;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic do_reset();
    idle();
    i_hold     = 1'b0;
    i_flags_rd = 1'b0;
    i_rn_addr  = 3'd0;
    i_rst_n    = 1'b0;
    tick();
    tick();
    i_rst_n = 1'b1;
    tick();
  endtask

  // Push one result through and let it commit (two edges)
  task automatic write_commit(input logic [2:0] rd, input logic [31:0] res,
                              input logic we, input logic sf, input logic [3:0] apsr);
    drive(1'b1, rd, res, we, sf, apsr);
    tick();
    idle();
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge i_clk);
    if (o_ready_v() !== 1'b1) begin
      $display("FAIL reset_ready got=%b exp=1", o_ready_v()); failures++;
    end
    checks++;
    if (o_rn_data !== 32'h0) begin
      $display("FAIL reset_rn_data got=%h exp=00000000", o_rn_data); failures++;
    end
    checks++;
    if (o_apsr !== 4'h0 || o_hazard !== 1'b0 || o_retired !== 16'h0) begin
      $display("FAIL reset_outputs got apsr=%b hazard=%b retired=%0d exp 0/0/0",
               o_apsr, o_hazard, o_retired); failures++;
    end
    checks++;
    // Transfer to r2, then reset while S1 holds it
    tick();
    drive(1'b1, 3'd2, 32'h55, 1'b1, 1'b1, 4'hF);
    tick();
    idle();
    i_rst_n = 1'b0;
    @(negedge i_clk);
    if (o_retired !== 16'h0 || o_ready_v() !== 1'b1) begin
      $display("FAIL reset_mid_xfer got retired=%0d ready=%b exp 0/1",
               o_retired, o_ready_v()); failures++;
    end
    checks++;
    tick();
    i_rst_n = 1'b1;
    tick();
    tick();
    i_rn_addr = 3'd2;
    @(negedge i_clk);
    if (o_rn_data !== 32'h0 || o_apsr !== 4'h0 || o_retired !== 16'h0) begin
      $display("FAIL reset_discard got r2=%h apsr=%b retired=%0d exp 0/0/0",
               o_rn_data, o_apsr, o_retired); failures++;
    end
    checks++;
  endtask

  function automatic logic o_ready_v();
    return wb.o_ready;
  endfunction

  task automatic test_single_write();
    do_reset();
    i_rn_addr = 3'd3;
    drive(1'b1, 3'd3, 32'h0000_00A5, 1'b1, 1'b1, 4'b0100);
    tick();
    idle();
    @(negedge i_clk);
`ifdef ALU_WB_BYPASS_EN
    if (o_rn_data !== 32'hA5 || o_hazard !== 1'b0) begin
      $display("FAIL single_pending got data=%h hazard=%b exp 000000a5/0", o_rn_data, o_hazard);
      failures++;
    end
`else
    if (o_rn_data !== 32'h0 || o_hazard !== 1'b1) begin
      $display("FAIL single_pending got data=%h hazard=%b exp 00000000/1", o_rn_data, o_hazard);
      failures++;
    end
`endif
    checks++;
    tick();
    @(negedge i_clk);
    if (o_rn_data !== 32'hA5 || o_apsr !== 4'b0100 || o_retired !== 16'd1) begin
      $display("FAIL single_write got data=%h apsr=%b retired=%0d exp 000000a5/0100/1",
               o_rn_data, o_apsr, o_retired); failures++;
    end
    checks++;
    if (o_hazard !== 1'b0) begin
      $display("FAIL single_hazard_clear got=%b exp=0", o_hazard); failures++;
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    logic [2:0]  rds  [3];
    int          ready_low;
    vals = '{32'h10, 32'h20, 32'h30};
    rds  = '{3'd1, 3'd2, 3'd1};
    ready_low = 0;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, rds[k], vals[k], 1'b1, 1'b0, 4'h0);
      @(negedge i_clk);
      if (wb.o_ready !== 1'b1) ready_low++;
      tick();
    end
    idle();
    tick();
    if (ready_low != 0) begin
      $display("FAIL b2b_ready got low_cycles=%0d exp=0", ready_low); failures++;
    end
    checks++;
    i_rn_addr = 3'd1;
    @(negedge i_clk);
    if (o_rn_data !== 32'h30) begin
      $display("FAIL b2b_r1 got=%h exp=00000030", o_rn_data); failures++;
    end
    checks++;
    tick();
    i_rn_addr = 3'd2;
    @(negedge i_clk);
    if (o_rn_data !== 32'h20 || o_retired !== 16'd3) begin
      $display("FAIL b2b_r2 got r2=%h retired=%0d exp 00000020/3", o_rn_data, o_retired);
      failures++;
    end
    checks++;
  endtask

  task automatic test_hold();
    do_reset();
    write_commit(3'd6, 32'h11, 1'b1, 1'b0, 4'h0);
    i_rn_addr = 3'd6;
    // Hold raised while S1 is empty: the result still loads
    i_hold = 1'b1;
    drive(1'b1, 3'd6, 32'h22, 1'b1, 1'b0, 4'h0);
    @(negedge i_clk);
    if (wb.o_ready !== 1'b1) begin
      $display("FAIL hold_empty_ready got=%b exp=1", wb.o_ready); failures++;
    end
    checks++;
    tick();
    idle();
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
`ifdef ALU_WB_BYPASS_EN
      if (wb.o_ready !== 1'b0 || o_retired !== 16'd1 || o_rn_data !== 32'h22) begin
        $display("FAIL hold_cycle%0d got ready=%b retired=%0d r6=%h exp 0/1/00000022",
                 c, wb.o_ready, o_retired, o_rn_data); failures++;
      end
`else
      if (wb.o_ready !== 1'b0 || o_retired !== 16'd1 || o_rn_data !== 32'h11) begin
        $display("FAIL hold_cycle%0d got ready=%b retired=%0d r6=%h exp 0/1/00000011",
                 c, wb.o_ready, o_retired, o_rn_data); failures++;
      end
`endif
      checks++;
      tick();
    end
    i_hold = 1'b0;
    @(negedge i_clk);
    if (wb.o_ready !== 1'b1 || o_retired !== 16'd1) begin
      $display("FAIL hold_release got ready=%b retired=%0d exp 1/1", wb.o_ready, o_retired);
      failures++;
    end
    checks++;
    tick();
    @(negedge i_clk);
    if (o_rn_data !== 32'h22 || o_retired !== 16'd2 || o_hazard !== 1'b0) begin
      $display("FAIL hold_commit got r6=%h retired=%0d hazard=%b exp 00000022/2/0",
               o_rn_data, o_retired, o_hazard); failures++;
    end
    checks++;
  endtask

  task automatic test_compare();
    do_reset();
    write_commit(3'd5, 32'h7, 1'b1, 1'b0, 4'h0);
    write_commit(3'd5, 32'hFFFF, 1'b0, 1'b1, 4'b1010);
    i_rn_addr = 3'd5;
    @(negedge i_clk);
    if (o_rn_data !== 32'h7 || o_apsr !== 4'b1010 || o_retired !== 16'd2) begin
      $display("FAIL compare got r5=%h apsr=%b retired=%0d exp 00000007/1010/2",
               o_rn_data, o_apsr, o_retired); failures++;
    end
    checks++;
    // Register write without setflags leaves APSR alone
    tick();
    write_commit(3'd5, 32'h9, 1'b1, 1'b0, 4'b0001);
    @(negedge i_clk);
    if (o_rn_data !== 32'h9 || o_apsr !== 4'b1010) begin
      $display("FAIL noflags got r5=%h apsr=%b exp 00000009/1010", o_rn_data, o_apsr);
      failures++;
    end
    checks++;
  endtask

  task automatic test_pending_read();
    do_reset();
    write_commit(3'd4, 32'h1234, 1'b1, 1'b0, 4'h0);
    i_rn_addr = 3'd4;
    drive(1'b1, 3'd4, 32'hDEAD_BEEF, 1'b1, 1'b1, 4'b1000);
    tick();
    idle();
    i_hold = 1'b1;
    @(negedge i_clk);
`ifdef ALU_WB_BYPASS_EN
    if (o_rn_data !== 32'hDEAD_BEEF || o_hazard !== 1'b0) begin
      $display("FAIL pend_rn got data=%h hazard=%b exp deadbeef/0", o_rn_data, o_hazard);
      failures++;
    end
`else
    if (o_rn_data !== 32'h1234 || o_hazard !== 1'b1) begin
      $display("FAIL pend_rn got data=%h hazard=%b exp 00001234/1", o_rn_data, o_hazard);
      failures++;
    end
`endif
    checks++;
    // Different register, flags not read: no hazard in either build
    i_rn_addr  = 3'd0;
    i_flags_rd = 1'b0;
    #1;
    if (o_hazard !== 1'b0 || o_rn_data !== 32'h0) begin
      $display("FAIL pend_other got hazard=%b data=%h exp 0/00000000", o_hazard, o_rn_data);
      failures++;
    end
    checks++;
    i_flags_rd = 1'b1;
    #1;
`ifdef ALU_WB_BYPASS_EN
    if (o_hazard !== 1'b0 || o_apsr !== 4'b1000) begin
      $display("FAIL pend_flags got hazard=%b apsr=%b exp 0/1000", o_hazard, o_apsr);
      failures++;
    end
`else
    if (o_hazard !== 1'b1 || o_apsr !== 4'b0000) begin
      $display("FAIL pend_flags got hazard=%b apsr=%b exp 1/0000", o_hazard, o_apsr);
      failures++;
    end
`endif
    checks++;
    tick();
    i_hold     = 1'b0;
    i_rn_addr  = 3'd4;
    tick();
    @(negedge i_clk);
    if (o_rn_data !== 32'hDEAD_BEEF || o_hazard !== 1'b0 || o_apsr !== 4'b1000) begin
      $display("FAIL pend_commit got data=%h hazard=%b apsr=%b exp deadbeef/0/1000",
               o_rn_data, o_hazard, o_apsr); failures++;
    end
    checks++;
    i_flags_rd = 1'b0;
  endtask

  task automatic test_counter_wrap();
    do_reset();
    for (int k = 0; k < 17; k++) begin
      drive(1'b1, 3'd7, k, 1'b0, 1'b0, 4'h0);
      tick();
    end
    idle();
    tick();
    @(negedge i_clk);
    if (o_retired4 !== 4'd1) begin
      $display("FAIL wrap_cnt4 got=%0d exp=1", o_retired4); failures++;
    end
    checks++;
    if (o_retired !== 16'd17) begin
      $display("FAIL wrap_cnt16 got=%0d exp=17", o_retired); failures++;
    end
    checks++;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    i_rst_n    = 1'b0;
    i_hold     = 1'b0;
    i_flags_rd = 1'b0;
    i_rn_addr  = 3'd0;
    idle();
    test_reset();
    test_single_write();
    test_back_to_back();
    test_hold();
    test_compare();
    test_pending_read();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
